// File: rtl/decode_stage_if.sv
// Decode stage bus: IF/ID inputs, writeback port, fetch feedback and ID/IX pipeline register outputs.
// slave is the decode stage's view; master is the driving environment's view.
interface decode_stage_if;
   logic [15:0] inst_ifid_p2;
   logic [15:0] pc_p2;
   logic [15:0] nxt_pc_p2;
   logic        branch_taken_ixif_p3;
   logic        wb_en_p5;
   logic [2:0]  wb_reg_p5;
   logic [15:0] wb_data_p5;
   logic        stall_idif_p2;
   logic        illegal_op_idif_p3;
   logic        return_execution_idif_p3;
   logic        halted_p3;
   logic        valid_idix_p3;
   logic [4:0]  opcode_idix_p3;
   logic [15:0] rs_data_idix_p3;
   logic [15:0] rt_data_idix_p3;
   logic [15:0] imm_idix_p3;
   logic [2:0]  rd_idix_p3;
   logic        regwr_idix_p3;
   logic        memrd_idix_p3;
   logic [15:0] pc_idix_p3;
   logic [15:0] nxt_pc_idix_p3;

   modport slave (
      input  inst_ifid_p2, pc_p2, nxt_pc_p2, branch_taken_ixif_p3,
      input  wb_en_p5, wb_reg_p5, wb_data_p5,
      output stall_idif_p2, illegal_op_idif_p3, return_execution_idif_p3, halted_p3,
      output valid_idix_p3, opcode_idix_p3, rs_data_idix_p3, rt_data_idix_p3, imm_idix_p3,
      output rd_idix_p3, regwr_idix_p3, memrd_idix_p3, pc_idix_p3, nxt_pc_idix_p3
   );

   modport master (
      output inst_ifid_p2, pc_p2, nxt_pc_p2, branch_taken_ixif_p3,
      output wb_en_p5, wb_reg_p5, wb_data_p5,
      input  stall_idif_p2, illegal_op_idif_p3, return_execution_idif_p3, halted_p3,
      input  valid_idix_p3, opcode_idix_p3, rs_data_idix_p3, rt_data_idix_p3, imm_idix_p3,
      input  rd_idix_p3, regwr_idix_p3, memrd_idix_p3, pc_idix_p3, nxt_pc_idix_p3
   );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register file, opcode classification, fetch redirects, load-use stall, ID/IX register.
// Define DECODE_WB_BYPASS_EN for same-cycle writeback forwarding instead of a one-cycle writeback stall.
module decode_stage #(
   parameter int unsigned NUM_REGS      = 8,
   parameter logic [31:0] VALID_OP_MASK = 32'hFFFF_FF0F,
   parameter int unsigned SQUASH_CYC    = 2
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);
   localparam int unsigned CNT_W = (SQUASH_CYC < 32'd1) ? 32'd1 : $clog2(SQUASH_CYC + 32'd1);
   localparam logic [CNT_W-1:0] SQ_FULL   = CNT_W'(SQUASH_CYC);
   localparam logic [CNT_W-1:0] SQ_BRANCH = (SQUASH_CYC == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(SQUASH_CYC - 32'd1);
   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_SIIC = 5'b00010;
   localparam logic [4:0] OP_RTI  = 5'b00011;
   localparam logic [4:0] OP_LOAD = 5'b10001;

   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SQUASH = 2'd1, ST_HALTED = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      rf_q [NUM_REGS];

   logic [4:0]  op_s;
   logic [2:0]  rs_idx_s, rt_idx_s, rd_s;
   logic [15:0] rs_data_s, rt_data_s, imm_s;
   logic        illegal_s, regwr_s, memrd_s, load_use_s, wb_hazard_s, stall_s;

   logic        valid_d, valid_q, illegal_d, illegal_q, rti_d, rti_q, halted_d, halted_q;
   logic [4:0]  op_q;
   logic [15:0] rs_data_q, rt_data_q, imm_q, pc_q, nxt_pc_q;
   logic [2:0]  rd_q;
   logic        regwr_q, memrd_q;

   assign op_s      = bus.inst_ifid_p2[15:11];
   assign rs_idx_s  = bus.inst_ifid_p2[10:8];
   assign rt_idx_s  = bus.inst_ifid_p2[7:5];
   assign imm_s     = {{11{bus.inst_ifid_p2[4]}}, bus.inst_ifid_p2[4:0]};
   assign rd_s      = (op_s[4:3] == 2'b11) ? bus.inst_ifid_p2[4:2] : bus.inst_ifid_p2[7:5];
   assign memrd_s   = (op_s == OP_LOAD);
   assign regwr_s   = op_s[4] | memrd_s;
   assign illegal_s = ~VALID_OP_MASK[op_s] | (op_s == OP_SIIC);

   // Register file operand reads
   always_comb begin
      rs_data_s = rf_q[rs_idx_s];
      rt_data_s = rf_q[rt_idx_s];
`ifdef DECODE_WB_BYPASS_EN
      if (bus.wb_en_p5 && (bus.wb_reg_p5 == rs_idx_s)) begin
         rs_data_s = bus.wb_data_p5;
      end else begin
         rs_data_s = rf_q[rs_idx_s];
      end
      if (bus.wb_en_p5 && (bus.wb_reg_p5 == rt_idx_s)) begin
         rt_data_s = bus.wb_data_p5;
      end else begin
         rt_data_s = rf_q[rt_idx_s];
      end
`endif
   end

`ifdef DECODE_WB_BYPASS_EN
   assign wb_hazard_s = 1'b0;
`else
   // Without forwarding, hold fetch one cycle so the pending write lands before the operand is read.
   assign wb_hazard_s = bus.wb_en_p5 & ((bus.wb_reg_p5 == rs_idx_s) | (bus.wb_reg_p5 == rt_idx_s));
`endif

   assign load_use_s = valid_q & memrd_q & ((rd_q == rs_idx_s) | (rd_q == rt_idx_s));
   assign stall_s    = (state_q == ST_RUN) & ~bus.branch_taken_ixif_p3 & (load_use_s | wb_hazard_s);

   // Control FSM next state and ID/IX valid/pulse generation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      rti_d     = 1'b0;
      halted_d  = halted_q;
      if (state_q == ST_HALTED) begin
         halted_d = 1'b1;
      end else if (bus.branch_taken_ixif_p3) begin
         cnt_d   = SQ_BRANCH;
         state_d = (SQ_BRANCH != {CNT_W{1'b0}}) ? ST_SQUASH : ST_RUN;
      end else if (state_q == ST_SQUASH) begin
         if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_RUN;
         end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = ST_SQUASH;
         end
      end else if (stall_s) begin
         valid_d = 1'b0;
      end else begin
         case (op_s)
            OP_HALT: begin
               halted_d = 1'b1;
               state_d  = ST_HALTED;
            end
            OP_RTI: begin
               rti_d   = 1'b1;
               cnt_d   = SQ_FULL;
               state_d = (SQ_FULL != {CNT_W{1'b0}}) ? ST_SQUASH : ST_RUN;
            end
            default: begin
               if (illegal_s) begin
                  illegal_d = 1'b1;
                  cnt_d     = SQ_FULL;
                  state_d   = (SQ_FULL != {CNT_W{1'b0}}) ? ST_SQUASH : ST_RUN;
               end else begin
                  valid_d = 1'b1;
               end
            end
         endcase
      end
   end

   // Architectural register file write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            rf_q[i] <= 16'h0000;
         end
      end else if (bus.wb_en_p5) begin
         rf_q[bus.wb_reg_p5] <= bus.wb_data_p5;
      end
   end

   // FSM state and ID/IX pipeline register; fields track the input, valid qualifies them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         cnt_q     <= {CNT_W{1'b0}};
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         rti_q     <= 1'b0;
         halted_q  <= 1'b0;
         op_q      <= 5'b00000;
         rs_data_q <= 16'h0000;
         rt_data_q <= 16'h0000;
         imm_q     <= 16'h0000;
         rd_q      <= 3'b000;
         regwr_q   <= 1'b0;
         memrd_q   <= 1'b0;
         pc_q      <= 16'h0000;
         nxt_pc_q  <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         rti_q     <= rti_d;
         halted_q  <= halted_d;
         op_q      <= op_s;
         rs_data_q <= rs_data_s;
         rt_data_q <= rt_data_s;
         imm_q     <= imm_s;
         rd_q      <= rd_s;
         regwr_q   <= regwr_s;
         memrd_q   <= memrd_s;
         pc_q      <= bus.pc_p2;
         nxt_pc_q  <= bus.nxt_pc_p2;
      end
   end

   assign bus.stall_idif_p2            = stall_s;
   assign bus.illegal_op_idif_p3       = illegal_q;
   assign bus.return_execution_idif_p3 = rti_q;
   assign bus.halted_p3                = halted_q;
   assign bus.valid_idix_p3            = valid_q;
   assign bus.opcode_idix_p3           = op_q;
   assign bus.rs_data_idix_p3          = rs_data_q;
   assign bus.rt_data_idix_p3          = rt_data_q;
   assign bus.imm_idix_p3              = imm_q;
   assign bus.rd_idix_p3               = rd_q;
   assign bus.regwr_idix_p3            = regwr_q;
   assign bus.memrd_idix_p3            = memrd_q;
   assign bus.pc_idix_p3               = pc_q;
   assign bus.nxt_pc_idix_p3           = nxt_pc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: per-cycle reference model plus directed vectors with literal expectations.
module tb_decode_stage;
   localparam int SQ = 2;

   logic clk = 1'b0;
   logic rst_n;
   decode_stage_if bus();

   decode_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic        model_on = 1'b0;
   int          squash_left;
   logic        m_halted;
   logic [15:0] m_rf [8];
   logic        e_valid, e_ill, e_ret, e_halt, e_regwr, e_memrd;
   logic [4:0]  e_op;
   logic [15:0] e_rs, e_rt, e_imm, e_pc, e_nxt;
   logic [2:0]  e_rd;

   task automatic model_clear();
      squash_left = 0;
      m_halted = 1'b0;
      for (int r = 0; r < 8; r++) m_rf[r] = 16'h0000;
      e_valid = 1'b0; e_ill = 1'b0; e_ret = 1'b0; e_halt = 1'b0;
   endtask

   initial begin
      logic [15:0] inst, rs_val, rt_val;
      logic [4:0]  op;
      logic        m_stall, lu, wbh;
      forever begin
         @(negedge clk);
         if (!model_on) begin
            if (rst_n === 1'b0) begin
               model_on = 1'b1;
               model_clear();
            end
         end else begin
            chk("valid", bus.valid_idix_p3, e_valid);
            chk("illegal_pulse", bus.illegal_op_idif_p3, e_ill);
            chk("rti_pulse", bus.return_execution_idif_p3, e_ret);
            chk("halted", bus.halted_p3, e_halt);
            if (e_valid) begin
               chk("opcode", bus.opcode_idix_p3, e_op);
               chk("rs_data", bus.rs_data_idix_p3, e_rs);
               chk("rt_data", bus.rt_data_idix_p3, e_rt);
               chk("imm", bus.imm_idix_p3, e_imm);
               chk("rd", bus.rd_idix_p3, e_rd);
               chk("regwr", bus.regwr_idix_p3, e_regwr);
               chk("memrd", bus.memrd_idix_p3, e_memrd);
               chk("pc", bus.pc_idix_p3, e_pc);
               chk("nxt_pc", bus.nxt_pc_idix_p3, e_nxt);
            end
            inst   = bus.inst_ifid_p2;
            op     = inst[15:11];
            rs_val = m_rf[inst[10:8]];
            rt_val = m_rf[inst[7:5]];
`ifdef DECODE_WB_BYPASS_EN
            if (bus.wb_en_p5 && bus.wb_reg_p5 == inst[10:8]) rs_val = bus.wb_data_p5;
            if (bus.wb_en_p5 && bus.wb_reg_p5 == inst[7:5])  rt_val = bus.wb_data_p5;
            wbh = 1'b0;
`else
            wbh = bus.wb_en_p5 && (bus.wb_reg_p5 == inst[10:8] || bus.wb_reg_p5 == inst[7:5]);
`endif
            lu = e_valid && e_memrd && (e_rd == inst[10:8] || e_rd == inst[7:5]);
            m_stall = !m_halted && squash_left == 0 && !bus.branch_taken_ixif_p3 && (lu || wbh);
            if (rst_n) chk("stall", bus.stall_idif_p2, m_stall);

            if (!rst_n) begin
               model_clear();
            end else begin
               if (bus.wb_en_p5) m_rf[bus.wb_reg_p5] = bus.wb_data_p5;
               e_valid = 1'b0; e_ill = 1'b0; e_ret = 1'b0;
               if (m_halted) begin
               end else if (bus.branch_taken_ixif_p3) begin
                  squash_left = SQ - 1;
               end else if (squash_left > 0) begin
                  squash_left--;
               end else if (m_stall) begin
               end else if (op == 5'd0) begin
                  m_halted = 1'b1;
               end else if (op == 5'd3) begin
                  e_ret = 1'b1; squash_left = SQ;
               end else if (op == 5'd2 || (op >= 5'd4 && op <= 5'd7)) begin
                  e_ill = 1'b1; squash_left = SQ;
               end else begin
                  e_valid = 1'b1;
                  e_op    = op;
                  e_rs    = rs_val;
                  e_rt    = rt_val;
                  e_imm   = 16'($signed(inst[4:0]));
                  e_rd    = (op >= 5'd24) ? inst[4:2] : inst[7:5];
                  e_regwr = (op >= 5'd16);
                  e_memrd = (op == 5'd17);
                  e_pc    = bus.pc_p2;
                  e_nxt   = bus.nxt_pc_p2;
               end
               e_halt = m_halted;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   logic [15:0] pc = 16'h0000;

   // Present one instruction like fetch does: hold it while stalled, bounded retries.
   task automatic issue(input logic [15:0] inst);
      logic st;
      int   tries;
      tries = 0;
      bus.inst_ifid_p2 = inst;
      bus.pc_p2        = pc;
      bus.nxt_pc_p2    = pc + 16'd2;
      do begin
         @(negedge clk);
         st = bus.stall_idif_p2;
         @(posedge clk); #1;
         tries++;
      end while (st && tries < 4);
      if (st) begin
         n_checks++; n_fail++;
         $display("FAIL stall_bound: got stalled for %0d cycles, expected at most 3", tries);
      end
      pc = pc + 16'd2;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.inst_ifid_p2 = 16'h0800; bus.pc_p2 = 16'h0000; bus.nxt_pc_p2 = 16'h0002;
      bus.branch_taken_ixif_p3 = 1'b0;
      bus.wb_en_p5 = 1'b0; bus.wb_reg_p5 = 3'd0; bus.wb_data_p5 = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", bus.valid_idix_p3, 1'b0);
      chk("reset_halted", bus.halted_p3, 1'b0);
      chk("reset_pc", bus.pc_idix_p3, 16'h0000);
      rst_n = 1'b1;

      // NOP at PC 0
      issue(16'h0800);
      chk("nop_valid", bus.valid_idix_p3, 1'b1);
      chk("nop_opcode", bus.opcode_idix_p3, 5'd1);
      chk("nop_nxt_pc", bus.nxt_pc_idix_p3, 16'h0002);

      // R3 = 0xBEEF, then read it as rs
      bus.wb_en_p5 = 1'b1; bus.wb_reg_p5 = 3'd3; bus.wb_data_p5 = 16'hBEEF;
      issue(16'h0800);
      bus.wb_en_p5 = 1'b0;
      issue(16'h4300);
      chk("rs_beef", bus.rs_data_idix_p3, 16'hBEEF);

      // Same-cycle write of R5 and read as rt
      bus.wb_en_p5 = 1'b1; bus.wb_reg_p5 = 3'd5; bus.wb_data_p5 = 16'h1234;
      bus.inst_ifid_p2 = 16'h40A0; bus.pc_p2 = pc; bus.nxt_pc_p2 = pc + 16'd2;
      @(negedge clk);
`ifdef DECODE_WB_BYPASS_EN
      chk("wb_same_cycle_stall", bus.stall_idif_p2, 1'b0);
      @(posedge clk); #1;
      bus.wb_en_p5 = 1'b0;
`else
      chk("wb_same_cycle_stall", bus.stall_idif_p2, 1'b1);
      @(posedge clk); #1;
      bus.wb_en_p5 = 1'b0;
      chk("wb_stall_bubble", bus.valid_idix_p3, 1'b0);
      @(negedge clk);
      chk("wb_stall_released", bus.stall_idif_p2, 1'b0);
      @(posedge clk); #1;
`endif
      chk("rt_same_cycle", bus.rt_data_idix_p3, 16'h1234);
      pc = pc + 16'd2;

      // Illegal opcode 5: pulse, two bubbles, third valid
      issue(16'h2800);
      chk("illegal_pulse_lit", bus.illegal_op_idif_p3, 1'b1);
      chk("illegal_bubble", bus.valid_idix_p3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         issue(16'h0800);
         chk("post_illegal_valid", bus.valid_idix_p3, (k == 2) ? 1'b1 : 1'b0);
      end

      // Load R2, then dependent rt=R2: one stall, one bubble
      issue(16'h8840);
      chk("load_memrd", bus.memrd_idix_p3, 1'b1);
      chk("load_rd", bus.rd_idix_p3, 3'd2);
      bus.inst_ifid_p2 = 16'h4040; bus.pc_p2 = pc; bus.nxt_pc_p2 = pc + 16'd2;
      @(negedge clk);
      chk("load_use_stall", bus.stall_idif_p2, 1'b1);
      @(posedge clk); #1;
      chk("load_use_bubble", bus.valid_idix_p3, 1'b0);
      @(negedge clk);
      chk("load_use_stall_end", bus.stall_idif_p2, 1'b0);
      @(posedge clk); #1;
      chk("dependent_valid", bus.valid_idix_p3, 1'b1);
      pc = pc + 16'd2;

      // RTI under a taken branch: no pulse, bubble, one more squashed cycle
      bus.branch_taken_ixif_p3 = 1'b1;
      issue(16'h1800);
      bus.branch_taken_ixif_p3 = 1'b0;
      chk("branch_rti_pulse", bus.return_execution_idif_p3, 1'b0);
      issue(16'h0800);
      chk("branch_squash", bus.valid_idix_p3, 1'b0);
      issue(16'h0800);
      chk("branch_resume", bus.valid_idix_p3, 1'b1);

      // Plain RTI
      issue(16'h1800);
      chk("rti_pulse_lit", bus.return_execution_idif_p3, 1'b1);
      for (int k = 0; k < 3; k++) issue(16'h0800);
      chk("post_rti_valid", bus.valid_idix_p3, 1'b1);

      // Negative immediate with rd from inst[4:2]
      issue(16'hC156);
      chk("imm_sext", bus.imm_idix_p3, 16'hFFF6);
      chk("rd_hi_form", bus.rd_idix_p3, 3'd5);
      chk("regwr_hi", bus.regwr_idix_p3, 1'b1);

      // HALT, then arbitrary traffic
      issue(16'h0000);
      chk("halt_lit", bus.halted_p3, 1'b1);
      for (int k = 0; k < 12; k++) begin
         bus.inst_ifid_p2 = 16'h0800 + 16'(k);
         bus.branch_taken_ixif_p3 = k[0];
         @(posedge clk); #1;
         chk("halted_sticky", bus.halted_p3, 1'b1);
         chk("halted_no_valid", bus.valid_idix_p3, 1'b0);
      end
      bus.branch_taken_ixif_p3 = 1'b0;
      bus.inst_ifid_p2 = 16'h0800;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("halt_reset", bus.halted_p3, 1'b0);
      rst_n = 1'b1;
      issue(16'h0800);
      chk("run_after_reset", bus.valid_idix_p3, 1'b1);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
